boss_aggro_ctrl: RTL and testbench
==================================

// Module: boss_aggro_ctrl
// PURPOSE
//   Upstream feeder of the boss movement stage. Tracks a per-player aggro score from damage events:
//   gain on hits, slow decay, class-dependent floor. Drives class_aggro / player_2_aggro, which the
//   movement stage compares to pick its jump target (player 2 wins only on strictly greater aggro).
//   Updates once per frame_tick while the game is running.
// PARAMETERS
//   AGGRO_MAX     15  saturation ceiling for both scores (fits 4 bits)
//   HIT_GAIN      2   aggro added per registered hit
//   DECAY_TICKS   60  active frame_ticks between decay steps (>=2)
//   MELEE_FLOOR   3   minimum player-1 aggro when char_class==0
//   RANGED_FLOOR  1   minimum player-1 aggro when char_class!=0
//   P2_FLOOR      1   minimum player-2 aggro
// PORTS
//   clk             in   1  system clock (single clock domain)
//   rst             in   1  asynchronous, active-high reset
//   frame_tick      in   1  one-cycle pulse per video frame
//   game_active     in   2  0=menu, 1=running, 2/3=paused/ended
//   char_class      in   2  player-1 class; 0=melee, other=ranged
//   p1_hit          in   1  one-cycle pulse: player 1 damaged the boss
//   p2_hit          in   1  one-cycle pulse: player 2 damaged the boss
//   p1_alive        in   1  player 1 alive
//   p2_alive        in   1  player 2 present and alive
//   class_aggro     out  4  player-1 aggro score (registered)
//   player_2_aggro  out  4  player-2 aggro score (registered)
// BEHAVIOUR
//   Reset (async, immediate): class_aggro=0, player_2_aggro=0, pending counters=0, decay_cnt=0.
//   Hit capture (every clk, game_active==1 only):
//   - p1_pend/p2_pend are 2-bit counters, +1 per hit pulse, saturate at 3.
//   - Hit in the same clk as frame_tick counts toward the NEXT frame (pend <= 1 after clear).
//   - game_active!=1: hit pulses ignored.
//   Frame update (frame_tick && game_active==1), per player, in order:
//   1. sum = aggro + pend*HIT_GAIN, saturate at AGGRO_MAX; pend cleared.
//   2. Decay event when decay_cnt==DECAY_TICKS-1, then decay_cnt wraps to 0; else decay_cnt+1.
//      On decay event, score -1 only if pend was 0 this tick (hit blocks decay) and sum>floor.
//   3. Result clamped up to floor; floor = MELEE_FLOOR or RANGED_FLOOR from char_class, P2_FLOOR for p2.
//   4. If alive==0: score forced 0, pend cleared. Overrides 1-3.
//   - Outputs change exactly one clk after the qualifying frame_tick; otherwise hold.
//   - char_class change takes effect at the next frame update; a lower floor never drops the score.
//   Menu (game_active==0, any clk, no tick needed):
//   - scores=0, pends=0, decay_cnt=0.
//   - First running tick after menu lifts scores to floors.
//   Pause/end (game_active 2/3): all state frozen, including decay_cnt.
//   Arithmetic: sum computed in 6 bits before saturation, so no wrap at AGGRO_MAX.
//   Scores never exceed AGGRO_MAX.
//   Reset asserted mid-frame discards pending hits.
// TESTING
//   1. rst, game_active=1, class=0, both alive, 1 tick -> class_aggro=3, player_2_aggro=1 one clk later.
//   2. 2 p2_hit pulses between ticks (p2 at 1) -> next tick player_2_aggro=5; class_aggro stays 3.
//   3. 5 p1_hit pulses in one frame -> pend saturates at 3; class_aggro 3->9 (+6, not +10).
//   4. p1 at 14, 3 hits -> 15 (saturated).
//      Then 60 idle ticks -> 14 exactly on the 60th; hit on a decay tick -> no decrement.
//   5. p2_alive=0 with player_2_aggro=9 -> 0 on next tick.
//      p2_hit while dead ignored; p2_alive=1 -> 1 next tick.
//   6. game_active=2 for 100 ticks with hits -> outputs and decay phase unchanged.
//      game_active=0 -> both 0 within 1 clk.
//      Async rst mid-frame with pend=2 -> outputs 0 before next clk edge, no gain on next tick.

Source files
------------

// File: rtl/boss_aggro_ctrl.sv
// boss_aggro_ctrl: per-player boss aggro tracker with hit gain, periodic decay and class floors
//   clk, rst                 clock, asynchronous active-high reset
//   frame_tick               one-cycle pulse per video frame
//   game_active[1:0]         0=menu, 1=running, 2/3=paused/ended
//   char_class[1:0]          player-1 class, 0=melee, other=ranged
//   p1_hit, p2_hit           one-cycle hit pulses
//   p1_alive, p2_alive       player alive flags
//   class_aggro[3:0]         player-1 aggro score
//   player_2_aggro[3:0]      player-2 aggro score
module boss_aggro_ctrl #(
    parameter int AGGRO_MAX    = 15,
    parameter int HIT_GAIN     = 2,
    parameter int DECAY_TICKS  = 60,
    parameter int MELEE_FLOOR  = 3,
    parameter int RANGED_FLOOR = 1,
    parameter int P2_FLOOR     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [1:0] game_active,
    input  logic [1:0] char_class,
    input  logic       p1_hit,
    input  logic       p2_hit,
    input  logic       p1_alive,
    input  logic       p2_alive,
    output logic [3:0] class_aggro,
    output logic [3:0] player_2_aggro
);
    localparam int DW = $clog2(DECAY_TICKS);

    logic [1:0]    p1_pend, p2_pend;
    logic [DW-1:0] decay_cnt;
    logic          decay_ev;
    logic [3:0]    p1_floor;

    // Sum is formed in 6 bits so a large pending gain saturates instead of wrapping.
    function automatic logic [3:0] score_next(input logic [3:0] aggro, input logic [1:0] pend,
                                              input logic [3:0] floor, input logic dec,
                                              input logic alive);
        logic [5:0] sum;
        logic [3:0] sat;
        sum = 6'(aggro) + 6'(pend) * 6'(HIT_GAIN);
        sat = (sum > 6'(AGGRO_MAX)) ? 4'(AGGRO_MAX) : sum[3:0];
        if (dec && pend == 2'd0 && sat > floor)
            sat = sat - 4'd1;
        return !alive ? 4'd0 : (sat < floor ? floor : sat);
    endfunction

    // Hits landing on the tick itself start the next frame's count; dead players gather nothing.
    function automatic logic [1:0] pend_next(input logic [1:0] pend, input logic hit,
                                             input logic alive, input logic tick);
        logic h;
        h = hit & alive;
        return tick ? {1'b0, h} : (pend == 2'd3 ? 2'd3 : pend + {1'b0, h});
    endfunction

    assign decay_ev = decay_cnt == DW'(DECAY_TICKS - 1);
    assign p1_floor = (char_class == 2'd0) ? 4'(MELEE_FLOOR) : 4'(RANGED_FLOOR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst || game_active == 2'd0) begin
            class_aggro    <= '0;
            player_2_aggro <= '0;
            p1_pend        <= '0;
            p2_pend        <= '0;
            decay_cnt      <= '0;
        end else if (game_active == 2'd1) begin
            p1_pend <= pend_next(p1_pend, p1_hit, p1_alive, frame_tick);
            p2_pend <= pend_next(p2_pend, p2_hit, p2_alive, frame_tick);
            if (frame_tick) begin
                class_aggro    <= score_next(class_aggro, p1_pend, p1_floor, decay_ev, p1_alive);
                player_2_aggro <= score_next(player_2_aggro, p2_pend, 4'(P2_FLOOR), decay_ev, p2_alive);
                decay_cnt      <= decay_ev ? '0 : decay_cnt + DW'(1);
            end
        end
    end
endmodule

// File: tb/tb_boss_aggro_ctrl.sv
// tb_boss_aggro_ctrl: directed and randomized checks of boss_aggro_ctrl against a frame-level score model
module tb_boss_aggro_ctrl;
    logic       clk = 1'b0;
    logic       rst, frame_tick, p1_hit, p2_hit, p1_alive, p2_alive;
    logic [1:0] game_active, char_class;
    logic [3:0] class_aggro, player_2_aggro;

    int compared = 0, mismatched = 0;
    int m1, m2, pd1, pd2, dc, s1, s2;

    always #5 clk = ~clk;

    boss_aggro_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active),
        .char_class(char_class), .p1_hit(p1_hit), .p2_hit(p2_hit),
        .p1_alive(p1_alive), .p2_alive(p2_alive),
        .class_aggro(class_aggro), .player_2_aggro(player_2_aggro)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int score(input int a, input int p, input int fl, input int ev, input int alive);
        int s;
        s = a + 2 * p;
        if (s > 15) s = 15;
        if (ev != 0 && p == 0 && s > fl) s = s - 1;
        if (s < fl) s = fl;
        return alive != 0 ? s : 0;
    endfunction

    task automatic model_zero();
        m1 = 0; m2 = 0; pd1 = 0; pd2 = 0; dc = 0;
    endtask

    task automatic model_step();
        int h1, h2, ev;
        h1 = (p1_hit && p1_alive) ? 1 : 0;
        h2 = (p2_hit && p2_alive) ? 1 : 0;
        if (rst || game_active == 0) model_zero();
        else if (game_active == 1) begin
            if (frame_tick) begin
                ev = (dc == 59) ? 1 : 0;
                m1 = score(m1, pd1, char_class == 0 ? 3 : 1, ev, p1_alive);
                m2 = score(m2, pd2, 1, ev, p2_alive);
                dc = (dc + 1) % 60;
                pd1 = h1;
                pd2 = h2;
            end else begin
                pd1 = (pd1 + h1 > 3) ? 3 : pd1 + h1;
                pd2 = (pd2 + h2 > 3) ? 3 : pd2 + h2;
            end
        end
    endtask

    task automatic cyc(input logic ft, input logic h1, input logic h2);
        frame_tick = ft; p1_hit = h1; p2_hit = h2;
        @(posedge clk);
        model_step();
        #1;
        frame_tick = 0; p1_hit = 0; p2_hit = 0;
        chk("p1_model", class_aggro, 4'(m1));
        chk("p2_model", player_2_aggro, 4'(m2));
    endtask

    task automatic tick();
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1; frame_tick = 0; p1_hit = 0; p2_hit = 0;
        game_active = 1; char_class = 0; p1_alive = 1; p2_alive = 1;
        model_zero();
        repeat (3) cyc(0, 0, 0);
        chk("reset_p1", class_aggro, 4'd0);
        chk("reset_p2", player_2_aggro, 4'd0);
        rst = 0;
        cyc(0, 0, 0);
        chk("pre_tick_p1", class_aggro, 4'd0);
        tick();
        chk("first_tick_p1", class_aggro, 4'd3);
        chk("first_tick_p2", player_2_aggro, 4'd1);
        cyc(0, 0, 1); cyc(0, 0, 1); tick();
        chk("p2_two_hits", player_2_aggro, 4'd5);
        chk("p1_unchanged", class_aggro, 4'd3);
        repeat (5) cyc(0, 1, 0);
        tick();
        chk("p1_pend_sat", class_aggro, 4'd9);
        cyc(0, 1, 0); cyc(0, 1, 0); tick();
        cyc(0, 1, 0); tick();
        chk("p1_sat_15", class_aggro, 4'd15);
        for (int i = 0; i < 70 && class_aggro != 4'd14; i++) tick();
        chk("first_decay", class_aggro, 4'd14);
        repeat (3) cyc(0, 1, 0);
        tick();
        chk("p1_14_plus_hits", class_aggro, 4'd15);
        repeat (58) tick();
        chk("no_early_decay", class_aggro, 4'd15);
        tick();
        chk("decay_on_60th", class_aggro, 4'd14);
        repeat (59) tick();
        cyc(0, 1, 0);
        tick();
        chk("hit_blocks_decay", class_aggro, 4'd15);
        repeat (3) cyc(0, 0, 1);
        tick();
        p2_alive = 0;
        cyc(0, 0, 1);
        tick();
        chk("p2_dead", player_2_aggro, 4'd0);
        cyc(0, 0, 1); cyc(0, 0, 1); tick();
        chk("p2_dead_hits", player_2_aggro, 4'd0);
        p2_alive = 1;
        tick();
        chk("p2_revive", player_2_aggro, 4'd1);
        s1 = m1; s2 = m2;
        game_active = 2;
        repeat (100) begin
            cyc(0, 1'($urandom), 1'($urandom));
            tick();
        end
        chk("pause_p1", class_aggro, 4'(s1));
        chk("pause_p2", player_2_aggro, 4'(s2));
        game_active = 1;
        repeat (70) tick();
        game_active = 0;
        cyc(0, 0, 0);
        chk("menu_p1", class_aggro, 4'd0);
        chk("menu_p2", player_2_aggro, 4'd0);
        game_active = 1;
        tick();
        chk("menu_lift_p1", class_aggro, 4'd3);
        chk("menu_lift_p2", player_2_aggro, 4'd1);
        cyc(0, 1, 0); cyc(0, 1, 0);
        rst = 1;
        model_zero();
        #1;
        chk("async_rst_p1", class_aggro, 4'd0);
        chk("async_rst_p2", player_2_aggro, 4'd0);
        #1;
        rst = 0;
        tick();
        chk("rst_drops_pend", class_aggro, 4'd3);
        repeat (1500) begin
            if ($urandom_range(0, 19) == 0)
                game_active = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
            if ($urandom_range(0, 29) == 0) char_class = 2'($urandom);
            if ($urandom_range(0, 39) == 0) p1_alive = ~p1_alive;
            if ($urandom_range(0, 39) == 0) p2_alive = ~p2_alive;
            cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
